// File: rtl/msg_receiver.sv
// rtl/msg_receiver.sv - sync-hunting message receiver writing payload to data RAM; optional MSG_RX_TIMEOUT_EN inter-byte timeout
`timescale 1ns/1ps
module msg_receiver #(
    parameter logic [15:0] SYNC_WORD      = 16'h1234,
    parameter int          RAM_ADDR_W     = 8,
    parameter int          MAX_DATA       = 256,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  S2PReady,
    input  logic [7:0]            InputByte,
    output logic                  S2PRead,
    output logic                  RamWrite,
    output logic [RAM_ADDR_W-1:0] RamAddr,
    output logic [7:0]            RamData,
    output logic [15:0]           MsgId,
    output logic [15:0]           DataCount,
    output logic                  MsgReady,
    input  logic                  MsgAck,
    output logic                  MsgError,
    output logic                  Busy
);

    // Ordered so that the busy states CountLo..WriteData form one contiguous range.
    localparam logic [3:0] HUNT_LO     = 4'd0;
    localparam logic [3:0] HUNT_HI     = 4'd1;
    localparam logic [3:0] COUNT_LO    = 4'd2;
    localparam logic [3:0] COUNT_HI    = 4'd3;
    localparam logic [3:0] ID_LO       = 4'd4;
    localparam logic [3:0] ID_HI       = 4'd5;
    localparam logic [3:0] CHECK_COUNT = 4'd6;
    localparam logic [3:0] GET_DATA    = 4'd7;
    localparam logic [3:0] WRITE_DATA  = 4'd8;
    localparam logic [3:0] DONE        = 4'd9;
    localparam logic [3:0] HOLD        = 4'd10;
    localparam logic [3:0] ERROR       = 4'd11;

    localparam logic [16:0] MAX_DATA_W = 17'(MAX_DATA);

    logic [3:0]            state;
    logic [3:0]            next_state;
    logic [15:0]           byte_count;
    logic [15:0]           msg_id_r;
    logic [15:0]           remaining;
    logic [15:0]           data_len;
    logic [RAM_ADDR_W-1:0] addr;
    logic                  accept;
    logic                  timed_out;

    // Header length is subtracted once; only meaningful after the <6 check.
    assign data_len = byte_count - 16'd6;
    assign accept   = S2PRead;

`ifdef MSG_RX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;
    logic        timed_state;

    assign timed_state = (state == COUNT_LO) || (state == COUNT_HI) || (state == ID_LO) ||
                         (state == ID_HI) || (state == GET_DATA);
    // Fires on the last idle cycle, so the FSM never accepts and aborts in the same cycle.
    assign timed_out   = timed_state && !accept && (idle_cnt == TIMEOUT_LAST);

    // Idle counter: cleared on accept, on state change and outside the byte-waiting states.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            idle_cnt <= 16'd0;
        end else if (!timed_state || accept || (next_state != state)) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timed_out      = 1'b0;
`endif

    // Byte handshake: only the byte-consuming states take from the shift register.
    always_comb begin
        S2PRead = 1'b0;
        case (state)
            HUNT_LO, HUNT_HI, COUNT_LO, COUNT_HI, ID_LO, ID_HI, GET_DATA: S2PRead = S2PReady;
            default: S2PRead = 1'b0;
        endcase
    end

    // Next-state decode for sync hunt, header parse, payload transfer and hand-off.
    always_comb begin
        next_state = state;
        case (state)
            HUNT_LO: begin
                if (accept && (InputByte == SYNC_WORD[7:0])) next_state = HUNT_HI;
            end
            HUNT_HI: begin
                if (accept) begin
                    if (InputByte == SYNC_WORD[15:8])     next_state = COUNT_LO;
                    else if (InputByte == SYNC_WORD[7:0]) next_state = HUNT_HI;
                    else                                  next_state = HUNT_LO;
                end
            end
            COUNT_LO: if (accept) next_state = COUNT_HI;
            COUNT_HI: if (accept) next_state = ID_LO;
            ID_LO:    if (accept) next_state = ID_HI;
            ID_HI:    if (accept) next_state = CHECK_COUNT;
            CHECK_COUNT: begin
                if ((byte_count < 16'd6) || ({1'b0, data_len} > MAX_DATA_W)) next_state = ERROR;
                else if (byte_count == 16'd6)                                next_state = DONE;
                else                                                         next_state = GET_DATA;
            end
            GET_DATA:   if (accept) next_state = WRITE_DATA;
            WRITE_DATA: next_state = (remaining == 16'd1) ? DONE : GET_DATA;
            DONE:       next_state = HOLD;
            HOLD:       if (MsgAck) next_state = HUNT_LO;
            ERROR:      next_state = HUNT_LO;
            default:    next_state = HUNT_LO;
        endcase
        if (timed_out) next_state = ERROR;
    end

    // State register, header fields, payload bookkeeping and registered outputs.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state      <= HUNT_LO;
            byte_count <= 16'd0;
            msg_id_r   <= 16'd0;
            remaining  <= 16'd0;
            addr       <= '0;
            RamWrite   <= 1'b0;
            RamAddr    <= '0;
            RamData    <= 8'd0;
            MsgId      <= 16'd0;
            DataCount  <= 16'd0;
            MsgReady   <= 1'b0;
            MsgError   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state    <= next_state;
            RamWrite <= (next_state == WRITE_DATA);
            MsgError <= (next_state == ERROR);
            Busy     <= (next_state >= COUNT_LO) && (next_state <= WRITE_DATA);
            if (next_state == WRITE_DATA) RamAddr <= addr;

            case (state)
                COUNT_LO: if (accept) byte_count[7:0]  <= InputByte;
                COUNT_HI: if (accept) byte_count[15:8] <= InputByte;
                ID_LO:    if (accept) msg_id_r[7:0]    <= InputByte;
                ID_HI:    if (accept) msg_id_r[15:8]   <= InputByte;
                CHECK_COUNT: begin
                    remaining <= data_len;
                    addr      <= '0;
                end
                GET_DATA: if (accept) RamData <= InputByte;
                WRITE_DATA: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 16'd1;
                end
                DONE: begin
                    MsgId     <= msg_id_r;
                    DataCount <= data_len;
                    MsgReady  <= 1'b1;
                end
                HOLD: if (MsgAck) MsgReady <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_receiver.sv
// tb/tb_msg_receiver.sv - directed self-checking bench for msg_receiver
`timescale 1ns/1ps
module tb_msg_receiver;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        S2PReady = 1'b0;
    logic [7:0]  InputByte = 8'd0;
    logic        MsgAck = 1'b0;
    logic        S2PRead;
    logic        RamWrite;
    logic [7:0]  RamAddr;
    logic [7:0]  RamData;
    logic [15:0] MsgId;
    logic [15:0] DataCount;
    logic        MsgReady;
    logic        MsgError;
    logic        Busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int wr_cnt     = 0;
    int err_cnt    = 0;
    logic [7:0] wr_addr [0:511];
    logic [7:0] wr_data [0:511];
    int base;
    int ebase;
    int viol;

    msg_receiver #(.TIMEOUT_CYCLES(50)) dut (
        .Clock(Clock), .Clear(Clear), .S2PReady(S2PReady), .InputByte(InputByte),
        .S2PRead(S2PRead), .RamWrite(RamWrite), .RamAddr(RamAddr), .RamData(RamData),
        .MsgId(MsgId), .DataCount(DataCount), .MsgReady(MsgReady), .MsgAck(MsgAck),
        .MsgError(MsgError), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Record RAM writes and error pulses on the falling edge.
    always @(negedge Clock) begin
        if (RamWrite && wr_cnt < 512) begin
            wr_addr[wr_cnt] = RamAddr;
            wr_data[wr_cnt] = RamData;
            wr_cnt = wr_cnt + 1;
        end
        if (MsgError) err_cnt = err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt = assert_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        InputByte = b;
        S2PReady  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (S2PRead) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("byte_accept", 32'(S2PRead), 32'd1);
        @(posedge Clock);
        #1;
        S2PReady = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (MsgReady) break;
        end
        check_eq(tag, 32'(MsgReady), 32'd1);
    endtask

    task automatic ack_msg();
        @(posedge Clock); #1;
        MsgAck = 1'b1;
        @(posedge Clock); #1;
        MsgAck = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        check_eq("rst_msg_ready", 32'(MsgReady), 32'd0);
        check_eq("rst_msg_id", 32'(MsgId), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_ram_write", 32'(RamWrite), 32'd0);
        check_eq("rst_s2p_read", 32'(S2PRead), 32'd0);
        Clear = 1'b0;
        idle(1);

        // Basic 3-byte payload
        base = wr_cnt;
        send_byte(8'h34); send_byte(8'h12);
        check_eq("busy_after_sync", 32'(Busy), 32'd1);
        send_byte(8'h09); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_ready("t1_ready");
        check_eq("t1_wr_count", 32'(wr_cnt - base), 32'd3);
        check_eq("t1_addr0", 32'(wr_addr[base]), 32'd0);
        check_eq("t1_data0", 32'(wr_data[base]), 32'hAA);
        check_eq("t1_addr1", 32'(wr_addr[base+1]), 32'd1);
        check_eq("t1_data1", 32'(wr_data[base+1]), 32'hBB);
        check_eq("t1_addr2", 32'(wr_addr[base+2]), 32'd2);
        check_eq("t1_data2", 32'(wr_data[base+2]), 32'hCC);
        check_eq("t1_msg_id", 32'(MsgId), 32'h0005);
        check_eq("t1_data_count", 32'(DataCount), 32'd3);
        check_eq("t1_ram_addr_hold", 32'(RamAddr), 32'd2);
        check_eq("t1_busy_hold", 32'(Busy), 32'd0);
        ack_msg();
        check_eq("t1_ready_cleared", 32'(MsgReady), 32'd0);
        S2PReady = 1'b1;
        #1;
        check_eq("t1_hunt_accepts", 32'(S2PRead), 32'd1);
        S2PReady = 1'b0;

        // Leading garbage, repeated sync low byte, empty payload
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h34); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h07); send_byte(8'h00);
        wait_ready("t2_ready");
        check_eq("t2_wr_count", 32'(wr_cnt - base), 32'd0);
        check_eq("t2_msg_id", 32'(MsgId), 32'h0007);
        check_eq("t2_data_count", 32'(DataCount), 32'd0);
        ack_msg();

        // Count too small, then one above the maximum
        base  = wr_cnt;
        ebase = err_cnt;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        idle(4);
        check_eq("t3_err_short", 32'(err_cnt - ebase), 32'd1);
        check_eq("t3_id_unchanged", 32'(MsgId), 32'h0007);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h07); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h00);
        idle(4);
        check_eq("t3_err_long", 32'(err_cnt - ebase), 32'd2);
        check_eq("t3_no_write", 32'(wr_cnt - base), 32'd0);
        check_eq("t3_no_ready", 32'(MsgReady), 32'd0);
        check_eq("t3_count_unchanged", 32'(DataCount), 32'd0);

        // Exactly the maximum payload is accepted
        base = wr_cnt;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h06); send_byte(8'h01);
        send_byte(8'h0F); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
        wait_ready("max_ready");
        check_eq("max_wr_count", 32'(wr_cnt - base), 32'd256);
        check_eq("max_last_addr", 32'(wr_addr[base+255]), 32'hFF);
        check_eq("max_last_data", 32'(wr_data[base+255]), 32'hA5);
        check_eq("max_data_count", 32'(DataCount), 32'd256);
        check_eq("max_err_none", 32'(err_cnt - ebase), 32'd2);
        ack_msg();

        // Backpressure while holding a message
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h06); send_byte(8'h00);
        send_byte(8'h09); send_byte(8'h00);
        wait_ready("t4_ready");
        InputByte = 8'h34;
        S2PReady  = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge Clock);
            if (S2PRead) viol = viol + 1;
        end
        check_eq("t4_hold_backpressure", 32'(viol), 32'd0);
        ack_msg();
        check_eq("t4_accept_after_ack", 32'(S2PRead), 32'd1);
        idle(1);
        S2PReady = 1'b0;

        // Asynchronous clear mid-payload, then a clean message from address 0
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h0A); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        #2;
        Clear = 1'b1;
        #1;
        check_eq("t5_clr_busy", 32'(Busy), 32'd0);
        check_eq("t5_clr_ram_write", 32'(RamWrite), 32'd0);
        check_eq("t5_clr_ram_addr", 32'(RamAddr), 32'd0);
        check_eq("t5_clr_ram_data", 32'(RamData), 32'd0);
        check_eq("t5_clr_msg_id", 32'(MsgId), 32'd0);
        idle(1);
        Clear = 1'b0;
        idle(1);
        base = wr_cnt;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h0C); send_byte(8'h00); send_byte(8'h5A); send_byte(8'hA5);
        wait_ready("t5_ready");
        check_eq("t5_wr_count", 32'(wr_cnt - base), 32'd2);
        check_eq("t5_addr0", 32'(wr_addr[base]), 32'd0);
        check_eq("t5_data0", 32'(wr_data[base]), 32'h5A);
        check_eq("t5_addr1", 32'(wr_addr[base+1]), 32'd1);
        check_eq("t5_data1", 32'(wr_data[base+1]), 32'hA5);
        check_eq("t5_msg_id", 32'(MsgId), 32'h000C);
        check_eq("t5_data_count", 32'(DataCount), 32'd2);
        ack_msg();

        ebase = err_cnt;
`ifdef MSG_RX_TIMEOUT_EN
        // 49 idle cycles are tolerated
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h09);
        idle(48);
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_ready("t6_ready_49");
        check_eq("t6_err_49", 32'(err_cnt - ebase), 32'd0);
        check_eq("t6_msg_id", 32'(MsgId), 32'h0005);
        ack_msg();
        // 50 idle cycles abort the message
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h09);
        idle(49);
        idle(3);
        check_eq("t6_err_50", 32'(err_cnt - ebase), 32'd1);
        check_eq("t6_busy_50", 32'(Busy), 32'd0);
        check_eq("t6_ready_50", 32'(MsgReady), 32'd0);
`else
        // Without the timeout a long stall is harmless
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h09);
        idle(60);
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_ready("t6_ready_stall");
        check_eq("t6_err_stall", 32'(err_cnt - ebase), 32'd0);
        check_eq("t6_msg_id", 32'(MsgId), 32'h0005);
        ack_msg();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
